// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I mem stage: valid/ready request in,
// fixed wait states, byte/half/word little-endian access, registered response out.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] ERR_DATA = 32'hbadbadff;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_write;
  logic             lat_unsigned;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [1:0]       lat_size;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             enter_resp;
  logic             acc_write;
  logic             acc_unsigned;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [1:0]       acc_size;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             acc_err;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shift;
  logic [31:0]      load_data;
  logic [31:0]      resp_data;
  logic [3:0]       be;
  logic [31:0]      wdata_al;
  logic             mem_we;

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

  // In IDLE the access can only happen with zero wait states, so it uses the live request
  always_comb begin
    acc_write    = lat_write;
    acc_unsigned = lat_unsigned;
    acc_addr     = lat_addr;
    acc_wdata    = lat_wdata;
    acc_size     = lat_size;
    if (state == IDLE) begin
      acc_write    = req_write;
      acc_unsigned = req_unsigned;
      acc_addr     = req_addr;
      acc_wdata    = req_wdata;
      acc_size     = req_size;
    end
  end

  assign enter_resp = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt <= CNT_W'(1)));

  // Range check uses the raw address too, so wrap-around below BASE_ADDR never aliases
  assign offset  = acc_addr - BASE_ADDR;
  assign idx     = offset[IDX_W+1:2];
  assign acc_err = (acc_addr < BASE_ADDR) || (offset >= SPAN) ||
                   ((acc_size == 2'b01) && acc_addr[0]) ||
                   (acc_size[1] && (acc_addr[1:0] != 2'b00));

  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {acc_addr[1:0], 3'b000};

  always_comb begin
    load_data = rd_word;
    be        = 4'b1111;
    wdata_al  = acc_wdata;
    case (acc_size)
      2'b00: begin
        load_data = acc_unsigned ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
        be        = 4'b0001 << acc_addr[1:0];
        wdata_al  = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        load_data = acc_unsigned ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
        be        = acc_addr[1] ? 4'b1100 : 4'b0011;
        wdata_al  = {2{acc_wdata[15:0]}};
      end
      default: begin
        load_data = rd_word;
        be        = 4'b1111;
        wdata_al  = acc_wdata;
      end
    endcase
  end

  assign resp_data = acc_err ? ERR_DATA : (acc_write ? 32'h0 : load_data);
  assign mem_we    = enter_resp && acc_write && !acc_err;

  // Storage is never reset; writes only on the edge that enters RESP
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0;
      rsp_err      <= 1'b0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
      lat_size     <= 2'b00;
    end else begin
      if (enter_resp) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_rdata <= resp_data;
        rsp_err   <= acc_err;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write    <= req_write;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            lat_size     <= req_size;
            if (WAIT_CYCLES != 0) begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES);
            end
          end
        end
        WAIT: cnt <= cnt - CNT_W'(1);
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the pipelined RV32I core. It is the slave end of the mem stage's load/store request interface. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. It performs byte/half/word little-endian accesses with sign or zero extension and returns a registered response over a second valid/ready handshake. It replaces the zero-latency combinational data memory so the mem stage and the hazard/stall logic can be exercised against real memory latency.

Parameters:
BASE_ADDR, 32'h0100_0000, byte address of word 0; matches the core's reset PC region.
DEPTH_WORDS, 16384, number of 32-bit words of storage (64 KiB).
WAIT_CYCLES, 2, wait states between acceptance and response (0..15).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data; the low byte/half/word is used
req_size  input  2  2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 treated as word
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts the response
rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores
rsp_err  output  1  access was out of range or misaligned

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- FSM states are IDLE, WAIT and RESP.
- Reset (async assert): state goes to IDLE, wait counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latched request cleared. Memory contents are not reset.
- Reset mid-transaction: the pending request is discarded and a pending store is never committed.
- req_ready = 1 only in IDLE while rst_n = 1. It is a combinational decode of the state only and never depends on req_valid.
- Acceptance occurs on an edge with req_valid && req_ready. All req_* fields are latched at that edge. The requester may change its inputs afterwards.
- IDLE -> WAIT on acceptance, counter loaded with WAIT_CYCLES. If WAIT_CYCLES = 0, IDLE -> RESP directly.
- WAIT: the counter decrements each cycle. On the edge where the counter reaches 1, go to RESP.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the acceptance edge.
- Access on entering RESP (same edge):
  - Stores write only the addressed byte lanes: byte uses lane addr[1:0], half uses lanes addr[1]*2 and +1, word uses all four lanes. Data comes from latched wdata[7:0]/[15:0]/[31:0]. rsp_rdata = 0.
  - Loads read the addressed lane(s), then sign-extend or zero-extend per req_unsigned. A word load ignores req_unsigned.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
- On the handshake edge, go RESP -> IDLE and clear rsp_valid. rsp_rdata and rsp_err keep their last value.
- No back-to-back overlap. A new request can be accepted one cycle after the response handshake at the earliest.
- Error conditions:
  - addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH_WORDS.
  - half access with addr[0] = 1.
  - word access with addr[1:0] != 0.
  - On error: no memory update, rsp_rdata = 32'hbadbadff, rsp_err = 1, and latency is unchanged.
- Word index = (addr - BASE_ADDR) >> 2, computed in 32 bits. Address wrap-around below BASE_ADDR is caught by the range check and never aliases into memory.
- Ordering: a load observes every store whose response was previously delivered. Only one transaction is ever in flight.

Test Plan:
- Reset, WAIT_CYCLES=2, store word 0xDEADBEEF @0x01000010, then load word @0x01000010 unsigned=0. Required: each rsp_valid rises 3 cycles after acceptance, load returns 0xDEADBEEF with rsp_err=0.
- After the previous test, load byte @0x01000013 with unsigned=0 -> 0xFFFFFFDE. Same address with unsigned=1 -> 0x000000DE. Load half @0x01000010 with unsigned=0 -> 0xFFFFBEEF.
- Store byte 0x5A @0x01000011 over 0xDEADBEEF, then load word @0x01000010 -> 0xDEAD5AEF. Lane isolation is verified.
- Error cases:
  - load word @0x01000002 -> rsp_err=1, rdata=0xbadbadff.
  - store @0x00FFFFFC -> rsp_err=1, no memory change.
  - load @BASE+4*DEPTH_WORDS -> error.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP with req_valid=1 throughout. Required: rsp_rdata stable, req_ready=0 throughout, next acceptance 1 cycle after the handshake. With WAIT_CYCLES=0, latency = 1 cycle.
- Assert rst_n low in WAIT during a store of 0x11111111 @0x01000020. Required: outputs clear asynchronously, state is IDLE after release, and a subsequent load @0x01000020 returns the prior contents.
